// File: rtl/if_prefetch_unit_pkg.sv
// Shared types for the instruction-fetch prefetch unit.
// Optional macro IF_PREFETCH_BYPASS_EN (see if_prefetch_unit.sv) does not change this package.
package if_prefetch_unit_pkg;

    localparam int RV_XLEN      = 32;
    localparam int FETCH_STRIDE = 4;

    typedef logic [RV_XLEN-1:0] rv32i_word;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_REQ,
        IF_DISCARD
    } if_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fq_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fifo_sync.sv
// Synchronous circular FIFO with flush; head entry is always visible on o_rdata.
// Pointers wrap naturally because DEPTH is a power of two.
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_rdata = r_mem[r_head];

    // A pop frees the slot in the same cycle, so push is legal when full if popping.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy update; flush and reset both empty the queue.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + AW'(1);
            if (w_do_pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush && !i_rst) r_mem[r_tail] <= i_wdata;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// I-cache reads, buffers {pc, instr} in a DEPTH-entry queue, serves IF/ID.
// Queue space is reserved at issue time so a response can never overflow.
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to fq_* when
// the queue is empty (zero-cycle resp-to-ID latency).
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int             DEPTH    = 4,
    parameter int             XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h4000_0000)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_instr_read,
    output logic [XLEN-1:0] o_instr_mem_address,
    input  logic [XLEN-1:0] i_instr_mem_rdata,
    input  logic            i_instr_mem_resp,
    output logic            o_fq_valid,
    output logic [XLEN-1:0] o_fq_pc,
    output logic [XLEN-1:0] o_fq_instr,
    input  logic            i_id_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * XLEN;   // one {pc, instr} entry, same layout as fq_entry_t

    if_state_t       r_state, w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [XLEN-1:0] r_addr, w_addr_nxt;
    logic            r_read, w_read_nxt;

    logic [XLEN-1:0] w_redirect_tgt;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_resp_ok;
    logic            w_pop_req;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ_nxt;
    logic            w_space;
    logic [EW-1:0]   w_head;

    assign w_redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_pc_inc       = r_fetch_pc + XLEN'(FETCH_STRIDE);

    // A response is only useful in REQ with no redirect racing it.
    assign w_resp_ok = (r_state == IF_REQ) && i_instr_mem_resp && !i_redirect;
    // Redirect wins over a same-cycle pop.
    assign w_pop_req = o_fq_valid && i_id_ready && !i_redirect;

`ifdef IF_PREFETCH_BYPASS_EN
    logic w_bypass;
    // Empty queue: show the arriving response directly; skip the write if taken now.
    assign w_bypass            = w_resp_ok && w_empty;
    assign o_fq_valid          = !w_empty || w_bypass;
    assign o_fq_pc             = w_bypass ? r_fetch_pc : w_head[EW-1:XLEN];
    assign o_fq_instr          = w_bypass ? i_instr_mem_rdata : w_head[XLEN-1:0];
    assign w_push              = w_resp_ok && !(w_bypass && i_id_ready);
    assign w_pop               = w_pop_req && !w_empty;
`else
    assign o_fq_valid          = !w_empty;
    assign o_fq_pc             = w_head[EW-1:XLEN];
    assign o_fq_instr          = w_head[XLEN-1:0];
    assign w_push              = w_resp_ok;
    assign w_pop               = w_pop_req;
`endif

    // Occupancy after this cycle's push/pop; a new read may issue only if a slot remains.
    assign w_occ_nxt = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_space   = (w_occ_nxt < (CW+1)'(DEPTH)) && !(w_full && !w_pop);

    assign o_instr_read        = r_read;
    assign o_instr_mem_address = r_addr;

    fifo_sync #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_wdata ({r_fetch_pc, i_instr_mem_rdata}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state, fetch PC and registered bus request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IF_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_read     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_read     <= w_read_nxt;
        end
    end

    // Next-state: issue, back-to-back reissue, and redirect/discard handling.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        w_read_nxt     = r_read;
        unique case (r_state)
            IF_IDLE: begin
                if (i_redirect) begin
                    w_fetch_pc_nxt = w_redirect_tgt;
                end else if (w_space) begin
                    w_state_nxt = IF_REQ;
                    w_read_nxt  = 1'b1;
                    w_addr_nxt  = r_fetch_pc;
                end
            end
            IF_REQ: begin
                if (i_instr_mem_resp) begin
                    if (i_redirect) begin
                        // Data belongs to the old path: drop it.
                        w_fetch_pc_nxt = w_redirect_tgt;
                        w_state_nxt    = IF_IDLE;
                        w_read_nxt     = 1'b0;
                    end else begin
                        w_fetch_pc_nxt = w_pc_inc;
                        if (w_space) begin
                            w_addr_nxt = w_pc_inc;
                        end else begin
                            w_state_nxt = IF_IDLE;
                            w_read_nxt  = 1'b0;
                        end
                    end
                end else if (i_redirect) begin
                    // Old address stays on the bus until its response arrives.
                    w_state_nxt    = IF_DISCARD;
                    w_fetch_pc_nxt = w_redirect_tgt;
                end
            end
            IF_DISCARD: begin
                if (i_redirect) w_fetch_pc_nxt = w_redirect_tgt;
                if (i_instr_mem_resp) begin
                    w_state_nxt = IF_IDLE;
                    w_read_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IF_IDLE;
                w_read_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: a directed cycle table, hand sequences for the
// fill/drain/reset corners, and a random run against an in-order PC model.
module tb_if_prefetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst, redirect, id_ready, resp;
    logic [31:0] rpc, rdata;
    logic        read, valid;
    logic [31:0] addr, fq_pc, fq_instr;

    always #5 clk = ~clk;

    if_prefetch_unit #(.DEPTH(4), .XLEN(32), .RESET_PC(RST_PC)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_redirect          (redirect),
        .i_redirect_pc       (rpc),
        .o_instr_read        (read),
        .o_instr_mem_address (addr),
        .i_instr_mem_rdata   (rdata),
        .i_instr_mem_resp    (resp),
        .o_fq_valid          (valid),
        .o_fq_pc             (fq_pc),
        .o_fq_instr          (fq_instr),
        .i_id_ready          (id_ready)
    );

    int total = 0;
    int bad   = 0;

    // Model state: the next PC ID must see is simply the last target plus 4 per pop.
    logic [31:0] exp_pc;
    int          mem_mode;   // 0: respond every read cycle, 1: random, 2: stall
    logic        prev_read, prev_resp, prev_redir;
    logic [31:0] prev_addr;
    int          pops, resps;

    function automatic logic [31:0] dval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_pc     = RST_PC;
        prev_read  = 1'b0;
        prev_resp  = 1'b0;
        prev_redir = 1'b0;
        prev_addr  = '0;
    endtask

    // Holds reset for n cycles, checks reset outputs, releases reset in the same cycle.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; id_ready = 1'b0; resp = 1'b0; rpc = '0; rdata = '0;
        repeat (n) @(negedge clk);
        #1;
        chkb("rst_read", read, 1'b0);
        chk ("rst_addr", addr, RST_PC);
        chkb("rst_valid", valid, 1'b0);
        rst = 1'b0;
        clear_model();
    endtask

    // One cycle with the memory model answering and the scoreboard watching.
    task automatic run_cycle(input logic rd, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        redirect = rd; rpc = tgt; id_ready = rdy;
        case (mem_mode)
            0:       resp = read;
            1:       resp = read && ($urandom_range(0, 2) == 0);
            default: resp = 1'b0;
        endcase
        rdata = resp ? dval(addr) : $urandom;
        #1;
        if (prev_read && !prev_resp) begin
            chkb("hold_read", read, 1'b1);
            chk ("hold_addr", addr, prev_addr);
        end
        if (read) chk("addr_align", {30'b0, addr[1:0]}, 32'h0);
        if (prev_redir) chkb("flush_valid", valid, 1'b0);
        if (valid && rdy && !rd) begin
            chk("pop_pc", fq_pc, exp_pc);
            chk("pop_instr", fq_instr, dval(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rd) exp_pc = {tgt[31:2], 2'b00};
        if (resp) resps++;
        prev_read = read; prev_resp = resp; prev_addr = addr; prev_redir = rd;
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rsp;
        logic [31:0] rsp_addr;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic [31:0] t, input logic rdy,
                                input logic rs, input logic [31:0] ra, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.redir = rd; v.rpc = t; v.rdy = rdy; v.rsp = rs; v.rsp_addr = ra;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        int first_addr;
        int p0;
        logic seen;

        rst = 1'b1; redirect = 1'b0; id_ready = 1'b0; resp = 1'b0; rpc = '0; rdata = '0;
        mem_mode = 2; pops = 0; resps = 0;
        clear_model();

        // Cycles 1..17 after reset release: back-to-back fetch, redirect while a read
        // waits (resp 3 cycles later, dropped), then redirect racing a resp and a pop.
        tbl[0]  = mk(0, 0, 1, 0, 0,            1, RST_PC,         0, 0);
        tbl[1]  = mk(0, 0, 1, 1, RST_PC,       1, RST_PC,         0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0,            1, RST_PC+4,       1, RST_PC);
        tbl[3]  = mk(0, 0, 1, 1, RST_PC+4,     1, RST_PC+4,       0, 0);
        tbl[4]  = mk(1, 32'h4000_0100, 1, 0, 0, 1, RST_PC+8,      1, RST_PC+4);
        tbl[5]  = mk(0, 0, 1, 0, 0,            1, RST_PC+8,       0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0,            1, RST_PC+8,       0, 0);
        tbl[7]  = mk(0, 0, 1, 1, RST_PC+8,     1, RST_PC+8,       0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0,            0, 0,              0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0,            1, 32'h4000_0100,  0, 0);
        tbl[10] = mk(0, 0, 1, 1, 32'h4000_0100, 1, 32'h4000_0100, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0,            1, 32'h4000_0104,  1, 32'h4000_0100);
        tbl[12] = mk(1, 32'h4000_0202, 1, 1, 32'h4000_0104, 1, 32'h4000_0104, 1, 32'h4000_0100);
        tbl[13] = mk(0, 0, 1, 0, 0,            0, 0,              0, 0);
        tbl[14] = mk(0, 0, 1, 0, 0,            1, 32'h4000_0200,  0, 0);
        tbl[15] = mk(0, 0, 1, 1, 32'h4000_0200, 1, 32'h4000_0200, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0,            1, 32'h4000_0204,  1, 32'h4000_0200);

        do_reset(2);
`ifndef IF_PREFETCH_BYPASS_EN
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            redirect = tbl[i].redir; rpc = tbl[i].rpc; id_ready = tbl[i].rdy;
            resp = tbl[i].rsp; rdata = dval(tbl[i].rsp_addr);
            #1;
            chkb($sformatf("tbl%0d_read", i), read, tbl[i].e_read);
            if (tbl[i].e_read) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
            chkb($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), fq_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), fq_instr, dval(tbl[i].e_pc));
            end
        end
`endif

        // Stalled ID: exactly DEPTH responses accepted, then reads stop; drain resumes at +0x10.
        do_reset(1);
        mem_mode = 0; resps = 0;
        repeat (10) run_cycle(1'b0, '0, 1'b0);
        chk ("full_accepted", resps, 4);
        chkb("full_read_idle", read, 1'b0);
        chkb("full_valid", valid, 1'b1);
        p0 = pops; seen = 1'b0; first_addr = 0;
        repeat (12) begin
            run_cycle(1'b0, '0, 1'b1);
            if (read && !seen && addr != RST_PC + 32'hC) begin
                seen = 1'b1; first_addr = addr;
            end
        end
        chk("resume_addr", first_addr, RST_PC + 32'h10);
        chkb("drain_progress", (pops - p0) >= 8, 1'b1);

        // Fill / stream at full / drain, three rounds so the pointers wrap.
        do_reset(1);
        for (int r = 0; r < 3; r++) begin
            mem_mode = 0;
            repeat (8) run_cycle(1'b0, '0, 1'b0);
            chkb($sformatf("round%0d_full_noread", r), read, 1'b0);
            repeat (6) begin
                run_cycle(1'b0, '0, 1'b1);
                chkb($sformatf("round%0d_stream_valid", r), valid, 1'b1);
            end
            mem_mode = 2;
            repeat (6) run_cycle(1'b0, '0, 1'b1);
            chkb($sformatf("round%0d_drained", r), valid, 1'b0);
        end

        // Reset while a read is outstanding with two entries queued.
        do_reset(1);
        mem_mode = 0;
        repeat (2) run_cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1; resp = 1'b0; id_ready = 1'b0;
        #1;
        chkb("pre_rst_read", read, 1'b1);
        chk ("pre_rst_addr", addr, RST_PC + 8);
        @(negedge clk);
        #1;
        chkb("rst_mid_valid", valid, 1'b0);
        chkb("rst_mid_read", read, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chkb("post_rst_read", read, 1'b1);
        chk ("post_rst_addr", addr, RST_PC);

        // PC wrap at the top of the address space, then random traffic.
        do_reset(1);
        mem_mode = 0;
        run_cycle(1'b1, 32'hFFFF_FFFA, 1'b1);
        p0 = pops;
        repeat (12) run_cycle(1'b0, '0, 1'b1);
        chkb("wrap_progress", (pops - p0) >= 4, 1'b1);

        mem_mode = 1;
        p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            logic        rd;
            logic [31:0] t;
            rd = ($urandom_range(0, 24) == 0);
            t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : (32'h4000_0000 | 32'($urandom_range(0, 4095)));
            run_cycle(rd, t, $urandom_range(0, 3) != 0);
        end
        chkb("random_progress", (pops - p0) > 300, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
